mipi_rx_depacker_sequencer: RTL and testbench

Sequences the 4-lane CSI-2 payload stream from the packet decoder into the RAW depacker. It latches each long-packet header, gates and counts the payload beats, and appends flush and gap cycles so the depacker drains and re-aligns between lines. It also tracks frame and line state from short packets and flags protocol errors.

---
 rtl/mipi_rx_depacker_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_mipi_rx_depacker_sequencer.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mipi_rx_depacker_sequencer.sv
// Sequences CSI-2 long-packet payload into the RAW depacker: gates and counts
// beats, appends flush and gap cycles, tracks frame/line state and flags errors.
module mipi_rx_depacker_sequencer #(
  parameter int FLUSH_BEATS = 1,
  parameter int GAP_CYCLES  = 2
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        cfg_enable_i,
  input  logic        packet_start_i,
  input  logic [5:0]  data_type_i,
  input  logic [15:0] word_count_i,
  input  logic        payload_valid_i,
  input  logic [31:0] payload_i,
  output logic        depacker_data_valid_o,
  output logic [31:0] depacker_data_o,
  output logic [2:0]  depacker_packet_type_o,
  output logic        frame_active_o,
  output logic [15:0] line_count_o,
  output logic [15:0] frame_count_o,
  output logic        err_type_o,
  output logic        err_length_o,
  output logic        err_protocol_o
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PAYLOAD,
    ST_FLUSH,
    ST_GAP
  } state_t;

  localparam logic [5:0] DT_FS     = 6'h00;
  localparam logic [5:0] DT_FE     = 6'h01;
  localparam logic [5:0] DT_RAW10  = 6'h2B;
  localparam logic [5:0] DT_RAW12  = 6'h2C;
  localparam logic [5:0] DT_RAW14  = 6'h2D;
  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_BEATS - 1);
  localparam logic [3:0] GAP_LOAD   = 4'(GAP_CYCLES - 1);

  state_t      state;
  logic [13:0] beat_left;   // beats still expected, minus one
  logic [2:0]  flush_cnt;
  logic [3:0]  gap_cnt;

  logic        is_long;
  logic        is_fs;
  logic        is_fe;
  logic        type_ok;
  logic        wc_zero;
  logic        wc_ragged;
  logic        busy_header;
  logic [13:0] beats_m1;
  logic [1:0]  wc_m1_unused;

  assign is_long     = (data_type_i >= 6'h10);
  assign is_fs       = packet_start_i && (data_type_i == DT_FS);
  assign is_fe       = packet_start_i && (data_type_i == DT_FE);
  assign type_ok     = (data_type_i == DT_RAW10) || (data_type_i == DT_RAW12) ||
                       (data_type_i == DT_RAW14);
  assign wc_zero     = (word_count_i == 16'd0);
  assign wc_ragged   = (word_count_i[1:0] != 2'd0);
  assign busy_header = packet_start_i && is_long && (state != ST_IDLE);

  // ceil(wc/4) - 1 == floor((wc-1)/4); keeps a 16384-beat packet in 14 bits.
  assign {beats_m1, wc_m1_unused} = word_count_i - 16'd1;

  // NOTE: every register in this block is updated with <= so all of them
  // sample the same pre-edge values; mixing in = would create ordering races.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state                  <= ST_IDLE;
      beat_left              <= '0;
      flush_cnt              <= '0;
      gap_cnt                <= '0;
      depacker_data_valid_o  <= 1'b0;
      depacker_data_o        <= '0;
      depacker_packet_type_o <= '0;
      frame_active_o         <= 1'b0;
      line_count_o           <= '0;
      frame_count_o          <= '0;
      err_type_o             <= 1'b0;
      err_length_o           <= 1'b0;
      err_protocol_o         <= 1'b0;
    end else begin
      err_type_o     <= 1'b0;
      err_length_o   <= 1'b0;
      err_protocol_o <= busy_header;

      // Frame tracking runs in every state, independent of the payload path.
      if (is_fs) begin
        frame_active_o <= 1'b1;
        line_count_o   <= '0;
        frame_count_o  <= frame_count_o + 16'd1;
      end else if (is_fe) begin
        frame_active_o <= 1'b0;
      end

      unique case (state)
        ST_IDLE: begin
          depacker_data_valid_o <= 1'b0;
          depacker_data_o       <= '0;
          if (packet_start_i && is_long && cfg_enable_i) begin
            if (!type_ok)        err_type_o     <= 1'b1;
            if (!frame_active_o) err_protocol_o <= 1'b1;
            if (type_ok && frame_active_o) begin
              depacker_packet_type_o <= data_type_i[2:0];
              if (line_count_o != 16'hFFFF) line_count_o <= line_count_o + 16'd1;
              if (wc_zero) begin
                err_length_o <= 1'b1;
                gap_cnt      <= GAP_LOAD;
                state        <= ST_GAP;
              end else begin
                err_length_o <= wc_ragged;
                if (payload_valid_i) begin
                  // First beat may ride along with the header strobe.
                  depacker_data_valid_o <= 1'b1;
                  depacker_data_o       <= payload_i;
                  if (beats_m1 == 14'd0) begin
                    flush_cnt <= FLUSH_LOAD;
                    state     <= ST_FLUSH;
                  end else begin
                    beat_left <= beats_m1 - 14'd1;
                    state     <= ST_PAYLOAD;
                  end
                end else begin
                  beat_left <= beats_m1;
                  state     <= ST_PAYLOAD;
                end
              end
            end
          end
        end

        ST_PAYLOAD: begin
          if (payload_valid_i) begin
            depacker_data_valid_o <= 1'b1;
            depacker_data_o       <= payload_i;
            if (beat_left == 14'd0) begin
              flush_cnt <= FLUSH_LOAD;
              state     <= ST_FLUSH;
            end else begin
              beat_left <= beat_left - 14'd1;
            end
          end else begin
            // Truncated payload: abandon the line and re-align through GAP.
            err_length_o          <= 1'b1;
            depacker_data_valid_o <= 1'b0;
            depacker_data_o       <= '0;
            gap_cnt               <= GAP_LOAD;
            state                 <= ST_GAP;
          end
        end

        ST_FLUSH: begin
          depacker_data_valid_o <= 1'b1;
          depacker_data_o       <= '0;
          if (flush_cnt == 3'd0) begin
            gap_cnt <= GAP_LOAD;
            state   <= ST_GAP;
          end else begin
            flush_cnt <= flush_cnt - 3'd1;
          end
        end

        ST_GAP: begin
          depacker_data_valid_o <= 1'b0;
          depacker_data_o       <= '0;
          if (gap_cnt == 4'd0) begin
            state <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt - 4'd1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mipi_rx_depacker_sequencer.sv
// Randomised and directed checks of mipi_rx_depacker_sequencer against a
// timestamp-based reference model of the packet timeline.
module tb_mipi_rx_depacker_sequencer;

  localparam int FLUSH_BEATS = 1;
  localparam int GAP_CYCLES  = 2;

  logic        clk_i;
  logic        reset_n_i;
  logic        cfg_enable_i;
  logic        packet_start_i;
  logic [5:0]  data_type_i;
  logic [15:0] word_count_i;
  logic        payload_valid_i;
  logic [31:0] payload_i;
  logic        depacker_data_valid_o;
  logic [31:0] depacker_data_o;
  logic [2:0]  depacker_packet_type_o;
  logic        frame_active_o;
  logic [15:0] line_count_o;
  logic [15:0] frame_count_o;
  logic        err_type_o;
  logic        err_length_o;
  logic        err_protocol_o;

  mipi_rx_depacker_sequencer #(
    .FLUSH_BEATS(FLUSH_BEATS),
    .GAP_CYCLES (GAP_CYCLES)
  ) dut (
    .clk_i                 (clk_i),
    .reset_n_i             (reset_n_i),
    .cfg_enable_i          (cfg_enable_i),
    .packet_start_i        (packet_start_i),
    .data_type_i           (data_type_i),
    .word_count_i          (word_count_i),
    .payload_valid_i       (payload_valid_i),
    .payload_i             (payload_i),
    .depacker_data_valid_o (depacker_data_valid_o),
    .depacker_data_o       (depacker_data_o),
    .depacker_packet_type_o(depacker_packet_type_o),
    .frame_active_o        (frame_active_o),
    .line_count_o          (line_count_o),
    .frame_count_o         (frame_count_o),
    .err_type_o            (err_type_o),
    .err_length_o          (err_length_o),
    .err_protocol_o        (err_protocol_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        ps;
    logic [5:0]  dt;
    logic [15:0] wc;
    logic        pv;
    logic [31:0] pl;
    logic        en;
  } stim_t;

  stim_t stim_q[$];
  int    errors = 0;
  int    checks = 0;
  int    cyc    = 0;

  // Reference model: packet timeline expressed as cycle timestamps.
  logic        m_valid, m_fa, m_et, m_el, m_ep;
  logic [31:0] m_data;
  logic [2:0]  m_type;
  logic [15:0] m_lines, m_frames;
  bit          m_inpay;
  int          m_left, m_free_at, m_flush_end;

  logic [71:0] obs_vec, exp_vec;
  assign obs_vec = {depacker_data_valid_o, (depacker_data_valid_o ? depacker_data_o : 32'h0),
                    depacker_packet_type_o, frame_active_o, line_count_o, frame_count_o,
                    err_type_o, err_length_o, err_protocol_o};
  assign exp_vec = {m_valid, m_data, m_type, m_fa, m_lines, m_frames, m_et, m_el, m_ep};

  task automatic model_reset();
    m_valid = 0; m_fa = 0; m_et = 0; m_el = 0; m_ep = 0;
    m_data = '0; m_type = '0; m_lines = '0; m_frames = '0;
    m_inpay = 0; m_left = 0; m_free_at = 0; m_flush_end = -1;
  endtask

  task automatic model_edge(input stim_t s);
    bit idle, acc_now, fa_prev, sup;
    int n;
    cyc++;
    idle    = !m_inpay && (cyc >= m_free_at);
    fa_prev = m_fa;
    acc_now = 0;
    m_et = 0; m_el = 0; m_ep = 0; m_valid = 0; m_data = '0;
    if (s.ps && s.dt < 6'h10) begin
      if (s.dt == 6'h00) begin
        m_fa = 1; m_lines = '0; m_frames = m_frames + 16'd1;
      end else if (s.dt == 6'h01) begin
        m_fa = 0;
      end
    end else if (s.ps) begin
      if (!idle) m_ep = 1;
      else if (s.en) begin
        sup = (s.dt == 6'h2B) || (s.dt == 6'h2C) || (s.dt == 6'h2D);
        if (!sup) m_et = 1;
        if (!fa_prev) m_ep = 1;
        if (sup && fa_prev) begin
          m_type = s.dt[2:0];
          if (m_lines != 16'hFFFF) m_lines = m_lines + 16'd1;
          n = (int'(s.wc) + 3) / 4;
          if ((int'(s.wc) % 4) != 0) m_el = 1;
          if (n == 0) begin
            m_el = 1;
            m_free_at = cyc + 1 + GAP_CYCLES;
          end else begin
            m_inpay = 1; m_left = n; acc_now = 1;
          end
        end
      end
    end
    if (m_inpay) begin
      if (s.pv) begin
        m_valid = 1; m_data = s.pl; m_left--;
        if (m_left == 0) begin
          m_inpay     = 0;
          m_flush_end = cyc + FLUSH_BEATS;
          m_free_at   = cyc + 1 + FLUSH_BEATS + GAP_CYCLES;
        end
      end else if (!acc_now) begin
        m_el = 1; m_inpay = 0; m_free_at = cyc + 1 + GAP_CYCLES;
      end
    end else if (cyc <= m_flush_end) begin
      m_valid = 1; m_data = '0;
    end
  endtask

  task automatic push(input logic ps, input logic [5:0] dt, input logic [15:0] wc,
                      input logic pv, input logic en);
    stim_t s;
    s.ps = ps; s.dt = dt; s.wc = wc; s.pv = pv; s.pl = $urandom; s.en = en;
    stim_q.push_back(s);
  endtask

  task automatic q_idle(input int n, input bit noise);
    for (int i = 0; i < n; i++) push(1'b0, 6'h3F, 16'h0, noise ? 1'($urandom_range(0, 1)) : 1'b0, 1'b1);
  endtask

  task automatic q_line(input logic [5:0] dt, input logic [15:0] wc, input int nbeats,
                        input bit same, input logic en);
    push(1'b1, dt, wc, same, en);
    for (int i = 0; i < nbeats - int'(same); i++) push(1'b0, 6'h3F, 16'h0, 1'b1, en);
  endtask

  task automatic q_short(input logic [5:0] dt);
    push(1'b1, dt, 16'h0, 1'b0, 1'b1);
  endtask

  task automatic drive_next();
    stim_t s;
    s = stim_q.pop_front();
    packet_start_i  = s.ps;
    data_type_i     = s.dt;
    word_count_i    = s.wc;
    payload_valid_i = s.pv;
    payload_i       = s.pl;
    cfg_enable_i    = s.en;
    @(posedge clk_i);
    model_edge(s);
    #1;
  endtask

  task automatic clear_inputs();
    packet_start_i = 0; data_type_i = '0; word_count_i = '0;
    payload_valid_i = 0; payload_i = '0; cfg_enable_i = 1;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset_n_i = 0;
    repeat (2) @(posedge clk_i);
    #1;
    reset_n_i = 1;
    model_reset();
  endtask

  task automatic test_reset();
    clear_inputs();
    reset_n_i = 1;
    #2 reset_n_i = 0;
    #1;
    checks++; if (depacker_data_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", depacker_data_valid_o); end
    checks++; if (depacker_data_o !== 32'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", depacker_data_o); end
    checks++; if (depacker_packet_type_o !== 3'h0) begin errors++; $display("FAIL reset_type got=%h exp=0", depacker_packet_type_o); end
    checks++; if (frame_active_o !== 1'b0) begin errors++; $display("FAIL reset_frame_active got=%b exp=0", frame_active_o); end
    checks++; if (line_count_o !== 16'h0) begin errors++; $display("FAIL reset_line_count got=%h exp=0", line_count_o); end
    checks++; if (frame_count_o !== 16'h0) begin errors++; $display("FAIL reset_frame_count got=%h exp=0", frame_count_o); end
    checks++; if ({err_type_o, err_length_o, err_protocol_o} !== 3'b000) begin
      errors++; $display("FAIL reset_errors got=%b exp=000", {err_type_o, err_length_o, err_protocol_o});
    end
    repeat (2) @(posedge clk_i);
    #1;
    reset_n_i = 1;
    model_reset();
  endtask

  task automatic test_normal_line();
    int nval = 0, nerr = 0;
    q_idle(2, 0); q_short(6'h00); q_idle(1, 0);
    q_line(6'h2B, 16'd40, 10, 0, 1'b1);
    q_idle(5, 1);
    while (stim_q.size() > 0) begin
      drive_next();
      checks++;
      if (obs_vec !== exp_vec) begin errors++; $display("FAIL normal_line cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec); end
      if (depacker_data_valid_o === 1'b1) nval++;
      if ((err_type_o | err_length_o | err_protocol_o) === 1'b1) nerr++;
    end
    checks++; if (nval != 11) begin errors++; $display("FAIL normal_beats got=%0d exp=11", nval); end
    checks++; if (nerr != 0) begin errors++; $display("FAIL normal_errors got=%0d exp=0", nerr); end
    checks++; if (depacker_packet_type_o !== 3'd3) begin errors++; $display("FAIL normal_type got=%0d exp=3", depacker_packet_type_o); end
    checks++; if (line_count_o !== 16'd1) begin errors++; $display("FAIL normal_lines got=%0d exp=1", line_count_o); end
  endtask

  task automatic test_back_to_back();
    int nep = 0;
    q_line(6'h2B, 16'd16, 4, 1, 1'b1);     // last beat at L
    q_line(6'h2C, 16'd8, 0, 0, 1'b1);      // header at L+1: rejected
    q_idle(2, 0);
    q_line(6'h2D, 16'd8, 2, 1, 1'b1);      // header at L+4: accepted
    q_idle(6, 0);
    while (stim_q.size() > 0) begin
      drive_next();
      checks++;
      if (obs_vec !== exp_vec) begin errors++; $display("FAIL back_to_back cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec); end
      if (err_protocol_o === 1'b1) nep++;
    end
    checks++; if (nep != 1) begin errors++; $display("FAIL b2b_protocol_pulses got=%0d exp=1", nep); end
    checks++; if (line_count_o !== 16'd3) begin errors++; $display("FAIL b2b_lines got=%0d exp=3", line_count_o); end
  endtask

  task automatic test_truncation();
    int nval = 0, nel = 0;
    q_line(6'h2B, 16'd40, 6, 0, 1'b1);
    q_idle(6, 0);
    while (stim_q.size() > 0) begin
      drive_next();
      checks++;
      if (obs_vec !== exp_vec) begin errors++; $display("FAIL truncation cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec); end
      if (depacker_data_valid_o === 1'b1) nval++;
      if (err_length_o === 1'b1) nel++;
    end
    checks++; if (nval != 6) begin errors++; $display("FAIL trunc_beats got=%0d exp=6", nval); end
    checks++; if (nel != 1) begin errors++; $display("FAIL trunc_length_pulses got=%0d exp=1", nel); end
  endtask

  task automatic test_bad_type_length();
    int nval = 0, net = 0, nel = 0;
    q_line(6'h2A, 16'd40, 10, 0, 1'b1);
    q_idle(2, 0);
    q_line(6'h2C, 16'd42, 11, 0, 1'b1);
    q_idle(5, 0);
    while (stim_q.size() > 0) begin
      drive_next();
      checks++;
      if (obs_vec !== exp_vec) begin errors++; $display("FAIL bad_type_length cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec); end
      if (depacker_data_valid_o === 1'b1) nval++;
      if (err_type_o === 1'b1) net++;
      if (err_length_o === 1'b1) nel++;
    end
    checks++; if (net != 1) begin errors++; $display("FAIL badtype_pulses got=%0d exp=1", net); end
    checks++; if (nel != 1) begin errors++; $display("FAIL badlen_pulses got=%0d exp=1", nel); end
    checks++; if (nval != 12) begin errors++; $display("FAIL badlen_beats got=%0d exp=12", nval); end
    checks++; if (depacker_packet_type_o !== 3'd4) begin errors++; $display("FAIL badlen_type got=%0d exp=4", depacker_packet_type_o); end
  endtask

  task automatic test_frame_gating();
    int nval = 0, nep = 0;
    do_reset();
    q_line(6'h2B, 16'd8, 2, 0, 1'b1);
    q_idle(3, 0);
    q_short(6'h00);
    for (int l = 0; l < 3; l++) begin
      q_line(6'h2B, 16'd8, 2, 0, 1'b1);
      q_idle(3, 0);
    end
    q_short(6'h01); q_short(6'h00); q_idle(2, 0);
    while (stim_q.size() > 0) begin
      drive_next();
      checks++;
      if (obs_vec !== exp_vec) begin errors++; $display("FAIL frame_gating cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec); end
      if (depacker_data_valid_o === 1'b1) nval++;
      if (err_protocol_o === 1'b1) nep++;
    end
    checks++; if (nep != 1) begin errors++; $display("FAIL gating_protocol_pulses got=%0d exp=1", nep); end
    checks++; if (nval != 9) begin errors++; $display("FAIL gating_beats got=%0d exp=9", nval); end
    checks++; if (frame_count_o !== 16'd2) begin errors++; $display("FAIL gating_frames got=%0d exp=2", frame_count_o); end
    checks++; if (line_count_o !== 16'd0) begin errors++; $display("FAIL gating_lines got=%0d exp=0", line_count_o); end
  endtask

  task automatic test_cfg_disable();
    int nval = 0, nerr = 0;
    q_line(6'h2B, 16'd8, 2, 0, 1'b0);
    q_idle(3, 0);
    while (stim_q.size() > 0) begin
      drive_next();
      checks++;
      if (obs_vec !== exp_vec) begin errors++; $display("FAIL cfg_disable cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec); end
      if (depacker_data_valid_o === 1'b1) nval++;
      if ((err_type_o | err_length_o | err_protocol_o) === 1'b1) nerr++;
    end
    checks++; if (nval + nerr != 0) begin errors++; $display("FAIL cfg_disable_activity got=%0d exp=0", nval + nerr); end
  endtask

  task automatic test_random();
    logic [5:0] dts[5] = '{6'h2B, 6'h2C, 6'h2D, 6'h2A, 6'h30};
    q_short(6'h00);
    for (int p = 0; p < 60; p++) begin
      int r, n, nb;
      logic [15:0] wc;
      bit same;
      r = $urandom_range(0, 9);
      if (r == 0) q_short(6'h00);
      else if (r == 1) q_short(6'h01);
      else if (r == 2) q_short(6'($urandom_range(2, 15)));
      else begin
        wc   = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 48));
        n    = (int'(wc) + 3) / 4;
        nb   = ($urandom_range(0, 4) == 0 && n > 1) ? $urandom_range(1, n - 1) : n;
        same = 1'($urandom_range(0, 1));
        q_line(dts[$urandom_range(0, 4)], wc, nb, same, 1'($urandom_range(0, 9) != 0));
      end
      q_idle($urandom_range(0, 6), 1);
    end
    q_idle(20, 0);
    while (stim_q.size() > 0) begin
      drive_next();
      checks++;
      if (obs_vec !== exp_vec) begin errors++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec); end
    end
  endtask

  task automatic test_reset_mid_payload();
    int nval = 0;
    q_short(6'h00);
    q_line(6'h2B, 16'd40, 4, 0, 1'b1);
    while (stim_q.size() > 0) begin
      drive_next();
      checks++;
      if (obs_vec !== exp_vec) begin errors++; $display("FAIL pre_reset cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec); end
    end
    #2 reset_n_i = 0;
    #1;
    checks++; if (depacker_data_valid_o !== 1'b0) begin errors++; $display("FAIL midreset_valid got=%b exp=0", depacker_data_valid_o); end
    checks++; if (obs_vec !== 72'h0) begin errors++; $display("FAIL midreset_outputs got=%h exp=0", obs_vec); end
    clear_inputs();
    repeat (2) @(posedge clk_i);
    #1;
    reset_n_i = 1;
    model_reset();
    q_short(6'h00);
    q_line(6'h2C, 16'd12, 3, 0, 1'b1);
    q_idle(5, 0);
    while (stim_q.size() > 0) begin
      drive_next();
      checks++;
      if (obs_vec !== exp_vec) begin errors++; $display("FAIL post_reset cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec); end
      if (depacker_data_valid_o === 1'b1) nval++;
    end
    checks++; if (nval != 4) begin errors++; $display("FAIL post_reset_beats got=%0d exp=4", nval); end
    checks++; if (frame_count_o !== 16'd1) begin errors++; $display("FAIL post_reset_frames got=%0d exp=1", frame_count_o); end
    checks++; if (line_count_o !== 16'd1) begin errors++; $display("FAIL post_reset_lines got=%0d exp=1", line_count_o); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_normal_line();
    test_back_to_back();
    test_truncation();
    test_bad_type_length();
    test_frame_gating();
    test_cfg_disable();
    test_random();
    test_reset_mid_payload();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
